// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter on a 16x baud clock, fed by a small circular write FIFO.
// Frames stream back-to-back whenever the FIFO still holds data when a stop bit ends.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_16x_bps,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] din,
  input  logic       ovf_clr,
  output logic       tx,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       ovf
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      tick_q, tick_d;
  logic [2:0]      bitpos_q, bitpos_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ovf_q, ovf_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic            push, pop;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign busy  = (state_q != IDLE) || !empty;
  assign tx    = tx_q;
  assign ovf   = ovf_q;
  assign push  = wr_en && !full;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bitpos_d = bitpos_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tick_d  = 4'd0;
          state_d = START;
        end
      end
      START: begin
        tick_d = tick_q + 4'd1;
        if (tick_q == 4'd15) begin
          tick_d   = 4'd0;
          bitpos_d = 3'd0;
          state_d  = DATA;
        end
      end
      DATA: begin
        tick_d = tick_q + 4'd1;
        if (tick_q == 4'd15) begin
          tick_d  = 4'd0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bitpos_q == 3'd7) state_d = STOP;
          else                  bitpos_d = bitpos_q + 3'd1;
        end
      end
      STOP: begin
        tick_d = tick_q + 4'd1;
        if (tick_q == 4'd15) begin
          tick_d = 4'd0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so the line level changes on the edge itself
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    if (wr_en && full)     ovf_d = 1'b1;
    else if (ovf_clr)      ovf_d = 1'b0;
  end

  always_ff @(posedge clk_16x_bps or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tick_q   <= 4'd0;
      bitpos_q <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: 8'd0};
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bitpos_q <= bitpos_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a line monitor decodes frames and compares
// them against a queue of bytes the bench expects to see transmitted.
module tb_uart_tx_fifo;

  logic       clk_16x_bps;
  logic       rst;
  logic       wr_en;
  logic [7:0] din;
  logic       ovf_clr;
  logic       tx;
  logic       full;
  logic       empty;
  logic       busy;
  logic       ovf;

  int         checks = 0;
  int         errors = 0;
  int         cycleCount = 0;
  int         frameCount = 0;
  int         frameStarts[$];
  logic [7:0] sbQueue[$];

  uart_tx_fifo #(.FIFO_DEPTH(4)) dut (
    .clk_16x_bps(clk_16x_bps),
    .rst        (rst),
    .wr_en      (wr_en),
    .din        (din),
    .ovf_clr    (ovf_clr),
    .tx         (tx),
    .full       (full),
    .empty      (empty),
    .busy       (busy),
    .ovf        (ovf)
  );

  initial begin
    clk_16x_bps = 1'b0;
    forever #5 clk_16x_bps = ~clk_16x_bps;
  end

  initial begin
    forever begin
      @(posedge clk_16x_bps);
      cycleCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs; they are sampled by the next rising edge, then released.
  task automatic applyStimulus(input logic we, input logic [7:0] data, input logic clr);
    wr_en   = we;
    din     = data;
    ovf_clr = clr;
    @(posedge clk_16x_bps);
    #1;
    wr_en   = 1'b0;
    din     = 8'h00;
    ovf_clr = 1'b0;
  endtask

  // Line monitor: samples mid-bit and checks each decoded byte against the scoreboard.
  initial begin
    bit         monActive;
    int         monCnt;
    logic [7:0] monByte;
    logic [7:0] expByte;
    monActive = 1'b0;
    monCnt    = 0;
    monByte   = 8'h00;
    forever begin
      @(negedge clk_16x_bps);
      if (rst) begin
        monActive = 1'b0;
      end else if (!monActive) begin
        if (tx === 1'b0) begin
          monActive = 1'b1;
          monCnt    = 0;
          frameStarts.push_back(cycleCount);
        end
      end else begin
        monCnt++;
        if (monCnt == 8) checkOutput("start_bit", tx, 1'b0);
        if (monCnt >= 24 && monCnt <= 136 && ((monCnt - 24) % 16) == 0)
          monByte[(monCnt - 24) / 16] = tx;
        if (monCnt == 152) checkOutput("stop_bit", tx, 1'b1);
        if (monCnt == 159) begin
          monActive = 1'b0;
          frameCount++;
          checkOutput("frame_expected", sbQueue.size() != 0, 1'b1);
          if (sbQueue.size() != 0) begin
            expByte = sbQueue.pop_front();
            checkOutput("frame_byte", monByte, expByte);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] pat;
    logic       expTx;
    int         base;
    int         framesBefore;
    int         lowCount;
    int         busyCount;

    rst     = 1'b1;
    wr_en   = 1'b0;
    din     = 8'h00;
    ovf_clr = 1'b0;
    repeat (3) @(posedge clk_16x_bps);
    #1;
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_full", full, 1'b0);
    checkOutput("reset_empty", empty, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_ovf", ovf, 1'b0);
    #2 rst = 1'b0;
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] single frame 0x55");
    pat = 8'h55;
    sbQueue.push_back(pat);
    applyStimulus(1'b1, pat, 1'b0);
    checkOutput("write_empty", empty, 1'b0);
    checkOutput("write_busy", busy, 1'b1);
    for (int i = 0; i < 160; i++) begin
      @(posedge clk_16x_bps);
      #1;
      if (i < 16)       expTx = 1'b0;
      else if (i < 144) expTx = pat[(i - 16) / 16];
      else              expTx = 1'b1;
      checkOutput($sformatf("tx55_cycle%0d", i), tx, expTx);
      checkOutput($sformatf("busy55_cycle%0d", i), busy, 1'b1);
      if (i == 0) checkOutput("pop_empty", empty, 1'b1);
    end
    @(posedge clk_16x_bps);
    #1;
    checkOutput("busy_falls", busy, 1'b0);
    checkOutput("idle_tx", tx, 1'b1);
    repeat (5) applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] three back-to-back frames");
    base = frameStarts.size();
    framesBefore = frameCount;
    sbQueue.push_back(8'hA3);
    sbQueue.push_back(8'h0F);
    sbQueue.push_back(8'hFF);
    applyStimulus(1'b1, 8'hA3, 1'b0);
    applyStimulus(1'b1, 8'h0F, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkOutput("b2b_queued", empty, 1'b0);
    repeat (319) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("b2b_empty_after_third_pop", empty, 1'b1);
    checkOutput("b2b_busy", busy, 1'b1);
    repeat (200) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("b2b_frames", frameCount - framesBefore, 3);
    checkOutput("b2b_gap1", frameStarts[base + 1] - frameStarts[base], 160);
    checkOutput("b2b_gap2", frameStarts[base + 2] - frameStarts[base + 1], 160);
    checkOutput("b2b_sb_drained", sbQueue.size(), 0);

    $display("[TB] overflow with six writes");
    framesBefore = frameCount;
    for (int i = 0; i < 5; i++) sbQueue.push_back(8'h11 + 8'(i));
    applyStimulus(1'b1, 8'h11, 1'b0);
    checkOutput("ovf6_tx_before_pop", tx, 1'b1);
    applyStimulus(1'b1, 8'h12, 1'b0);
    checkOutput("ovf6_first_pop_tx", tx, 1'b0);
    applyStimulus(1'b1, 8'h13, 1'b0);
    applyStimulus(1'b1, 8'h14, 1'b0);
    checkOutput("ovf6_not_full_yet", full, 1'b0);
    applyStimulus(1'b1, 8'h15, 1'b0);
    checkOutput("ovf6_full_on_fifth", full, 1'b1);
    checkOutput("ovf6_no_ovf_yet", ovf, 1'b0);
    applyStimulus(1'b1, 8'h16, 1'b0);
    checkOutput("ovf6_ovf_set", ovf, 1'b1);
    checkOutput("ovf6_still_full", full, 1'b1);
    repeat (820) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("ovf6_frames", frameCount - framesBefore, 5);
    checkOutput("ovf6_sb_drained", sbQueue.size(), 0);
    checkOutput("ovf6_sticky", ovf, 1'b1);

    $display("[TB] overflow clear");
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("ovfclr_alone", ovf, 1'b0);
    for (int i = 0; i < 5; i++) sbQueue.push_back(8'h21 + 8'(i));
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h21 + 8'(i), 1'b0);
    checkOutput("ovfclr_full", full, 1'b1);
    applyStimulus(1'b1, 8'h26, 1'b1);
    checkOutput("ovfclr_set_wins", ovf, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("ovfclr_again", ovf, 1'b0);
    repeat (820) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("ovfclr_sb_drained", sbQueue.size(), 0);

    $display("[TB] reset during data bit 3");
    framesBefore = frameCount;
    sbQueue.push_back(8'hC3);
    sbQueue.push_back(8'hD1);
    sbQueue.push_back(8'hE2);
    applyStimulus(1'b1, 8'hC3, 1'b0);
    applyStimulus(1'b1, 8'hD1, 1'b0);
    applyStimulus(1'b1, 8'hE2, 1'b0);
    repeat (68) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("rst_tx_bit3_before", tx, 1'b0);
    checkOutput("rst_queued_before", empty, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("rst_tx_async", tx, 1'b1);
    checkOutput("rst_empty", empty, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    sbQueue.delete();
    repeat (3) @(posedge clk_16x_bps);
    #3 rst = 1'b0;
    lowCount  = 0;
    busyCount = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_16x_bps);
      if (tx !== 1'b1) lowCount++;
      if (busy !== 1'b0) busyCount++;
    end
    checkOutput("rst_no_spurious_tx", lowCount, 0);
    checkOutput("rst_no_busy", busyCount, 0);
    checkOutput("rst_no_frames", frameCount - framesBefore, 0);

    $display("[TB] steady-state streaming");
    #1;
    base = frameStarts.size();
    framesBefore = frameCount;
    sbQueue.push_back(8'h30);
    sbQueue.push_back(8'h31);
    applyStimulus(1'b1, 8'h30, 1'b0);
    applyStimulus(1'b1, 8'h31, 1'b0);
    for (int j = 0; j < 10; j++) begin
      repeat (159) applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput($sformatf("stream%0d_pre_occupied", j), empty, 1'b0);
      sbQueue.push_back(8'h40 + 8'(j));
      applyStimulus(1'b1, 8'h40 + 8'(j), 1'b0);
      checkOutput($sformatf("stream%0d_occupied", j), empty, 1'b0);
      checkOutput($sformatf("stream%0d_not_full", j), full, 1'b0);
      checkOutput($sformatf("stream%0d_no_ovf", j), ovf, 1'b0);
    end
    repeat (400) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("stream_frames", frameCount - framesBefore, 12);
    for (int k = 1; k < 12; k++)
      checkOutput($sformatf("stream_gap%0d", k), frameStarts[base + k] - frameStarts[base + k - 1], 160);
    checkOutput("stream_sb_drained", sbQueue.size(), 0);
    checkOutput("stream_idle_busy", busy, 1'b0);
    checkOutput("stream_idle_ovf", ovf, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
